// File: rtl/dmem_port_arbiter.sv
// Two-port valid/ready arbiter and sequencer for the single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default build is round-robin.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 72,
  parameter int MEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic                req_port_q, req_port_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                p0_err_q, p0_err_d;
  logic                p1_err_q, p1_err_d;

  logic                gnt0_s, gnt1_s, accept_s;
  logic                sel_we_s, sel_in_range_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Grant: port 0 always wins a tie, so port 1 can starve.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == IDLE) begin
      gnt0_s = p0_valid;
      gnt1_s = p1_valid & ~p0_valid;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  // Grant: on a tie the port that did not win last time is served.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == IDLE) begin
      gnt0_s = p0_valid & (~p1_valid | last_grant_q);
      gnt1_s = p1_valid & (~p0_valid | ~last_grant_q);
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Round-robin pointer follows every accept.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_s) begin
      last_grant_d = gnt1_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin pointer register; resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign p0_ready = gnt0_s;
  assign p1_ready = gnt1_s;
  assign accept_s = gnt0_s | gnt1_s;

  assign sel_we_s       = gnt1_s ? p1_we    : p0_we;
  assign sel_addr_s     = gnt1_s ? p1_addr  : p0_addr;
  assign sel_wdata_s    = gnt1_s ? p1_wdata : p0_wdata;
  assign sel_in_range_s = ({1'b0, sel_addr_s} < DEPTH_L);

  // Next-state and registered-output logic; strobes are decided at accept so they land in ISSUE.
  always_comb begin
    state_d     = state_q;
    req_port_d  = req_port_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = ISSUE;
          req_port_d  = gnt1_s;
          mem_addr_d  = sel_addr_s;
          mem_wdata_d = sel_wdata_s;
          if (sel_in_range_s) begin
            mem_we_d = sel_we_s;
            mem_re_d = ~sel_we_s;
          end else begin
            p0_err_d = ~gnt1_s;
            p1_err_d = gnt1_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_re_q) begin
          state_d = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        if (req_port_q) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = mem_rdata;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_port_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= {DATA_W{1'b0}};
      p1_rdata_q  <= {DATA_W{1'b0}};
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_port_q  <= req_port_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and sequencer for the 128 x 72-bit data memory. Shares the memory's single port between the writeback path (port 0) and the load/store path (port 1) using valid/ready request handshakes. Drives the memory write/read strobes, and returns read data or an address error to the requester that issued the request.

## Interface
Parameters:
- ADDR_W, 7, memory address width
- DATA_W, 72, data word width
- MEM_DEPTH, 128, number of valid words; any address >= MEM_DEPTH is an error

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pN_valid  in  1  request valid (N = 0, 1; same set of ports per requester)
- pN_ready  out  1  request accepted this cycle when pN_valid & pN_ready
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_rvalid  out  1  one-cycle pulse: pN_rdata valid
- pN_rdata  out  DATA_W  read data, held until next pN_rvalid
- pN_err  out  1  one-cycle pulse: accepted request had address >= MEM_DEPTH
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

## Operation
- FSM states:
  - IDLE: pN_ready may assert.
  - ISSUE: one cycle; memory strobes driven.
  - RD_WAIT: one cycle; mem_rdata sampled at its end.
- Transitions:
  - IDLE -> ISSUE on accept.
  - ISSUE -> RD_WAIT for an in-range read; otherwise ISSUE -> IDLE.
  - RD_WAIT -> IDLE.
- Grant in IDLE:
  - One port valid: that port gets ready.
  - Both valid: the port != last_grant gets ready.
  - At most one pN_ready high in any cycle.
  - last_grant updates on every accept.
- pN_ready is combinational from state, the valids and last_grant; it is 0 outside IDLE.
- Accepted request fields (port id, we, addr, wdata) are registered at accept. Requester inputs are don't-care afterwards.
- In-range write: mem_we=1 in ISSUE with the registered addr/wdata. No response pulse.
- In-range read: mem_re=1 in ISSUE. mem_rdata is captured at the end of RD_WAIT into the granted port's pN_rdata, and pN_rvalid pulses for one cycle (in IDLE).
- Out-of-range request (addr >= MEM_DEPTH):
  - No memory strobe.
  - pN_err pulses in the ISSUE cycle.
  - No rvalid.
- A requester may hold pN_valid while not ready; the request is not lost and is re-arbitrated every IDLE cycle.

## Timing
- Accept in cycle T.
- Write: mem_we in T+1; next accept possible in T+2. Sustained rate is 1 write per 2 cycles.
- Read:
  - mem_re in T+1, mem_rdata sampled at end of T+2.
  - pN_rvalid/pN_rdata in T+3.
  - Next accept possible in T+3, the same cycle as rvalid.
- Error: pN_err in T+1; next accept in T+2.
- All outputs except pN_ready are registered.
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
  - pN_rvalid=pN_err=0, pN_rdata=0.
  - pN_ready follows the IDLE rule after reset.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. In-flight reads are dropped with no rvalid. A write reaches memory only if mem_we was sampled before reset.
- Simultaneous pN_rvalid of one read and accept of a new request in the same cycle is legal.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: fixed priority. Port 0 always wins when both are valid; last_grant is unused. Port 1 can starve.
- Not defined: round-robin as described in Operation.

## Test plan
- Single write, then read: p0 writes addr 0x05 data 0x0A_BCDE_F012_3456_789A. mem_we is in T+1 with the same addr/data. A p0 read of 0x05 then gives p0_rvalid 3 cycles after its accept, with p0_rdata = 0x0A_BCDE_F012_3456_789A.
- Contention: p0 and p1 both hold valid for 4 requests each.
  - Round-robin: grants alternate p0,p1,p0,p1,... starting with p0.
  - With DMEM_ARB_FIXED_PRIO_EN: all p0 grants first, then p1.
  - Never two readys in the same cycle.
- Out-of-range: MEM_DEPTH=100, p1 reads addr 0x70. p1_err pulses in T+1; no mem_re and no p1_rvalid; the next accept happens in T+2.
- Back-to-back reads: p1 reads 0x10 then 0x11 with valid held high. Accepts occur 3 cycles apart, and each rvalid coincides with the next accept cycle.
- Reset mid-read: drive reset=0 during RD_WAIT. Outputs go to 0 immediately and no rvalid follows. After release, a p0 request is granted first.
